// File: rtl/timer_alarm_sched.sv
// Software alarm scheduler: keeps NumAlarms 64-bit deadlines and programs
// the earliest enabled one into an mtimecmp-style timer over a simple bus.
module timer_alarm_sched #(
    parameter int                      NumAlarms    = 4,
    parameter int                      AddressWidth = 32,
    parameter logic [AddressWidth-1:0] TimerBase    = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         arm_valid_i,
    output logic                         arm_ready_o,
    input  logic [$clog2(NumAlarms)-1:0] arm_id_i,
    input  logic                         arm_enable_i,
    input  logic [63:0]                  arm_deadline_i,
    output logic [NumAlarms-1:0]         fired_o,
    output logic                         err_o,
    output logic                         timer_req_o,
    output logic                         timer_we_o,
    output logic [AddressWidth-1:0]      timer_addr_o,
    output logic [3:0]                   timer_be_o,
    output logic [31:0]                  timer_wdata_o,
    input  logic                         timer_rvalid_i,
    input  logic                         timer_err_i,
    input  logic                         timer_intr_i
);
    localparam int IdW = $clog2(NumAlarms);

    typedef enum logic [2:0] {
        IDLE, SCAN, WR_HI_MAX, WR_LO, WR_HI, WAIT_IRQ
    } state_e;

    state_e               r_state, w_state_next;
    logic [NumAlarms-1:0] r_en, w_en_next, w_fire, r_fired;
    logic [63:0]          r_dl [NumAlarms];
    logic [IdW-1:0]       r_tgt_id, w_min_id;
    logic [63:0]          r_tgt_dl, w_min_dl;
    logic                 r_any, w_any, r_issued, r_err;
    logic                 w_wr, w_req, w_accept, w_irq, w_rsp, w_id_ok;

    assign w_wr        = (r_state == WR_HI_MAX) || (r_state == WR_LO)
                      || (r_state == WR_HI);
    assign arm_ready_o = (r_state == IDLE) || (r_state == WAIT_IRQ);
    assign w_accept    = arm_valid_i && arm_ready_o;
    assign w_id_ok     = int'(arm_id_i) < NumAlarms;
    assign w_irq       = (r_state == WAIT_IRQ) && timer_intr_i;
    assign w_rsp       = w_wr && timer_rvalid_i;
    assign w_req       = w_wr && !r_issued;

    // Earliest enabled deadline; strict compare keeps the lowest index on ties
    always_comb begin
        w_any    = 1'b0;
        w_min_dl = '1;
        w_min_id = '0;
        for (int i = 0; i < NumAlarms; i++) begin
            if (r_en[i] && (!w_any || r_dl[i] < w_min_dl)) begin
                w_any    = 1'b1;
                w_min_dl = r_dl[i];
                w_min_id = IdW'(i);
            end
        end
    end

    // Firing is applied before a same-cycle arm/cancel
    always_comb begin
        w_fire = '0;
        for (int i = 0; i < NumAlarms; i++) begin
            w_fire[i] = (r_en[i] && (r_dl[i] == r_tgt_dl))
                     || (IdW'(i) == r_tgt_id);
        end
        w_en_next = r_en;
        if (w_irq) begin
            w_en_next = r_en & ~w_fire;
        end
        if (w_accept && w_id_ok) begin
            w_en_next[arm_id_i] = arm_enable_i;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:      if (w_accept) w_state_next = SCAN;
            SCAN:      w_state_next = WR_HI_MAX;
            WR_HI_MAX: if (w_rsp) w_state_next = r_any ? WR_LO : IDLE;
            WR_LO:     if (w_rsp) w_state_next = WR_HI;
            WR_HI:     if (w_rsp) w_state_next = WAIT_IRQ;
            WAIT_IRQ:  if (w_accept || w_irq) w_state_next = SCAN;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_en     <= '0;
            r_fired  <= '0;
            r_err    <= 1'b0;
            r_issued <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_en     <= w_en_next;
            r_fired  <= w_irq ? w_fire : '0;
            r_err    <= r_err | (timer_rvalid_i & timer_err_i);
            r_issued <= w_rsp ? 1'b0 : (r_issued | w_req);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept && w_id_ok && arm_enable_i) begin
            r_dl[arm_id_i] <= arm_deadline_i;
        end
        if (r_state == SCAN) begin
            r_tgt_id <= w_min_id;
            r_tgt_dl <= w_min_dl;
            r_any    <= w_any;
        end
    end

    // Parking the high word at all-ones first avoids a spurious match
    // while the low word is being rewritten.
    always_comb begin
        timer_addr_o  = '0;
        timer_wdata_o = '0;
        if (w_req) begin
            unique case (r_state)
                WR_HI_MAX: begin
                    timer_addr_o  = TimerBase + AddressWidth'(12);
                    timer_wdata_o = 32'hFFFF_FFFF;
                end
                WR_LO: begin
                    timer_addr_o  = TimerBase + AddressWidth'(8);
                    timer_wdata_o = r_tgt_dl[31:0];
                end
                WR_HI: begin
                    timer_addr_o  = TimerBase + AddressWidth'(12);
                    timer_wdata_o = r_tgt_dl[63:32];
                end
                default: ;
            endcase
        end
    end

    assign timer_req_o = w_req;
    assign timer_we_o  = w_req;
    assign timer_be_o  = w_req ? 4'hF : 4'h0;
    assign fired_o     = r_fired;
    assign err_o       = r_err;

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Self-checking bench for timer_alarm_sched: vector table, corner-case
// sequences and randomized ops against a behavioural alarm model.
module tb_timer_alarm_sched;
    localparam int          N  = 4;
    localparam logic [31:0] TB = 32'h0000_0400;

    logic        clk_i, rst_ni;
    logic        arm_valid_i, arm_ready_o, arm_enable_i;
    logic [1:0]  arm_id_i;
    logic [63:0] arm_deadline_i;
    logic [3:0]  fired_o;
    logic        err_o, timer_req_o, timer_we_o;
    logic [31:0] timer_addr_o, timer_wdata_o;
    logic [3:0]  timer_be_o;
    logic        timer_rvalid_i, timer_err_i, timer_intr_i;

    timer_alarm_sched #(
        .NumAlarms(N), .AddressWidth(32), .TimerBase(TB)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .arm_valid_i(arm_valid_i), .arm_ready_o(arm_ready_o),
        .arm_id_i(arm_id_i), .arm_enable_i(arm_enable_i),
        .arm_deadline_i(arm_deadline_i),
        .fired_o(fired_o), .err_o(err_o),
        .timer_req_o(timer_req_o), .timer_we_o(timer_we_o),
        .timer_addr_o(timer_addr_o), .timer_be_o(timer_be_o),
        .timer_wdata_o(timer_wdata_o),
        .timer_rvalid_i(timer_rvalid_i), .timer_err_i(timer_err_i),
        .timer_intr_i(timer_intr_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  be;
        int          cyc;
    } wr_t;

    typedef struct {
        int          op;
        int          id;
        logic [63:0] dl;
        logic [3:0]  fired;
        logic        any;
        logic [63:0] tdl;
    } vec_t;

    wr_t         wlog[$];
    vec_t        vt[14];
    int          cyc, n_chk, n_fail;
    logic        pend, pend_lo, err_lo_inj;
    logic        m_en [N];
    logic [63:0] m_dl [N];
    logic [3:0]  f;
    int          t0, tr;

    initial begin
        clk_i = 0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    // Timer model: answers one cycle after each request
    initial begin
        pend = 0; pend_lo = 0;
        timer_rvalid_i = 0; timer_err_i = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                pend = 0; pend_lo = 0;
                timer_rvalid_i = 0; timer_err_i = 0;
            end else begin
                timer_rvalid_i = pend;
                timer_err_i    = pend && pend_lo && err_lo_inj;
                pend    = timer_req_o;
                pend_lo = (timer_addr_o == TB + 32'd8);
                if (timer_req_o)
                    wlog.push_back('{timer_addr_o, timer_wdata_o,
                                     timer_we_o, timer_be_o, cyc});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(output int t);
        int n = 0;
        while (!arm_ready_o && n < 100) begin
            @(negedge clk_i); #1;
            n++;
        end
        t = cyc;
        if (n >= 100) chk("ready_timeout", 64'(arm_ready_o), 1);
    endtask

    // kind: 0 arm, 1 cancel, 2 interrupt only
    task automatic op(input int kind, input int id, input logic [63:0] dl,
                      input logic irq, output logic [3:0] fo,
                      output int ta);
        int t;
        @(negedge clk_i); #1;
        wait_ready(t);
        ta             = cyc;
        arm_valid_i    = (kind != 2);
        arm_id_i       = 2'(id);
        arm_enable_i   = (kind == 0);
        arm_deadline_i = dl;
        timer_intr_i   = irq || (kind == 2);
        @(posedge clk_i); #1;
        fo           = fired_o;
        arm_valid_i  = 0;
        timer_intr_i = 0;
    endtask

    task automatic settle_check(input logic any, input logic [63:0] tdl,
                                input string nm);
        int t;
        int en = any ? 3 : 1;
        @(posedge clk_i); #1;
        chk({nm, "_pulse"}, 64'(fired_o), 0);
        wait_ready(t);
        chk({nm, "_nwr"}, 64'(wlog.size()), 64'(en));
        if (wlog.size() >= 1) begin
            chk({nm, "_w0"}, {wlog[0].addr, wlog[0].data},
                {TB + 32'd12, 32'hFFFF_FFFF});
            chk({nm, "_webe"}, {wlog[0].we, wlog[0].be}, 5'h1F);
        end
        if (en == 3 && wlog.size() >= 3) begin
            chk({nm, "_w1"}, {wlog[1].addr, wlog[1].data},
                {TB + 32'd8, tdl[31:0]});
            chk({nm, "_w2"}, {wlog[2].addr, wlog[2].data},
                {TB + 32'd12, tdl[63:32]});
        end
        wlog.delete();
    endtask

    function automatic logic model_min(output logic [63:0] mn);
        logic found = 0;
        mn = '1;
        for (int i = 0; i < N; i++)
            if (m_en[i] && (!found || m_dl[i] < mn)) begin
                found = 1;
                mn = m_dl[i];
            end
        return found;
    endfunction

    initial begin
        logic [63:0] mn, dl;
        logic        any, irq;
        logic [3:0]  ef;
        int          kind, id;

        n_chk = 0; n_fail = 0; err_lo_inj = 0;
        rst_ni = 0; arm_valid_i = 0; arm_id_i = 0; arm_enable_i = 0;
        arm_deadline_i = 0; timer_intr_i = 0;

        vt[0]  = '{0, 0, 64'd500, 4'b0000, 1, 64'd500};
        vt[1]  = '{0, 2, 64'd200, 4'b0000, 1, 64'd200};
        vt[2]  = '{2, 0, 64'd0, 4'b0100, 1, 64'd500};
        vt[3]  = '{2, 0, 64'd0, 4'b0001, 0, 64'd0};
        vt[4]  = '{0, 1, 64'd300, 4'b0000, 1, 64'd300};
        vt[5]  = '{0, 3, 64'd300, 4'b0000, 1, 64'd300};
        vt[6]  = '{2, 0, 64'd0, 4'b1010, 0, 64'd0};
        vt[7]  = '{0, 2, 64'h1_0000_0100, 4'b0000, 1, 64'h1_0000_0100};
        vt[8]  = '{0, 0, 64'h0_FFFF_FFFF, 4'b0000, 1, 64'h0_FFFF_FFFF};
        vt[9]  = '{1, 0, 64'd0, 4'b0000, 1, 64'h1_0000_0100};
        vt[10] = '{0, 1, 64'd1000, 4'b0000, 1, 64'd1000};
        vt[11] = '{0, 0, 64'd50, 4'b0000, 1, 64'd50};
        vt[12] = '{2, 0, 64'd0, 4'b0001, 1, 64'd1000};
        vt[13] = '{1, 1, 64'd0, 4'b0000, 1, 64'h1_0000_0100};

        #12;
        chk("rst_outs", {fired_o, err_o, timer_req_o, timer_we_o,
                         timer_be_o}, 0);
        chk("rst_bus", {timer_addr_o, timer_wdata_o}, 0);
        chk("rst_ready", 64'(arm_ready_o), 1);
        @(negedge clk_i); #1;
        rst_ni = 1;

        // Exact request timing from IDLE
        op(0, 1, 64'h0000_0001_0000_0100, 0, f, t0);
        wait_ready(tr);
        chk("t_waitirq", 64'(tr - t0), 8);
        if (wlog.size() == 3) begin
            chk("t_req0", 64'(wlog[0].cyc - t0), 2);
            chk("t_req1", 64'(wlog[1].cyc - t0), 4);
            chk("t_req2", 64'(wlog[2].cyc - t0), 6);
        end
        settle_check(1, 64'h0000_0001_0000_0100, "first");
        op(1, 1, 0, 0, f, t0);
        settle_check(0, 0, "first_cancel");

        for (int k = 0; k < 14; k++) begin
            op(vt[k].op, vt[k].id, vt[k].dl, 0, f, t0);
            chk($sformatf("vec%0d_fired", k), 64'(f), 64'(vt[k].fired));
            settle_check(vt[k].any, vt[k].tdl, $sformatf("vec%0d", k));
        end
        op(1, 2, 0, 0, f, t0);
        settle_check(0, 0, "vec_clean");

        // Bus error on the low-word write is sticky
        chk("err_before", 64'(err_o), 0);
        err_lo_inj = 1;
        op(0, 3, 64'd77, 0, f, t0);
        settle_check(1, 64'd77, "err_seq");
        chk("err_set", 64'(err_o), 1);
        err_lo_inj = 0;
        op(1, 3, 0, 0, f, t0);
        settle_check(0, 0, "err_after");
        chk("err_sticky", 64'(err_o), 1);

        // Interrupt and arm/cancel in the same WAIT_IRQ cycle
        op(0, 0, 64'd100, 0, f, t0);
        settle_check(1, 64'd100, "co_a");
        op(0, 0, 64'd700, 1, f, t0);
        chk("co_arm_fired", 64'(f), 4'b0001);
        settle_check(1, 64'd700, "co_b");
        op(1, 0, 0, 1, f, t0);
        chk("co_cancel_fired", 64'(f), 4'b0001);
        settle_check(0, 0, "co_c");

        // Reset in the middle of the low-word write
        op(0, 1, 64'd123, 0, f, t0);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk_i); #1;
            if (timer_req_o && timer_addr_o == TB + 32'd8) break;
        end
        chk("mid_in_wrlo", 64'(timer_req_o), 1);
        rst_ni = 0;
        #1;
        chk("mid_rst_outs", {fired_o, err_o, timer_req_o, timer_we_o,
                             timer_be_o}, 0);
        chk("mid_rst_bus", {timer_addr_o, timer_wdata_o}, 0);
        @(negedge clk_i); #1;
        rst_ni = 1;
        wlog.delete();
        timer_intr_i = 1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_i); #1;
            chk("post_rst_fired", 64'(fired_o), 0);
            chk("post_rst_req", 64'(timer_req_o), 0);
        end
        timer_intr_i = 0;
        chk("post_rst_nwr", 64'(wlog.size()), 0);
        chk("post_rst_ready", 64'(arm_ready_o), 1);

        // Randomized ops against the alarm model
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0;
            m_dl[i] = 0;
        end
        for (int it = 0; it < 60; it++) begin
            any  = model_min(mn);
            kind = int'($urandom_range(0, 4));
            kind = (kind < 3) ? 0 : (kind == 3) ? 1 : 2;
            if (kind == 2 && !any) kind = 0;
            id  = int'($urandom_range(0, N - 1));
            dl  = {($urandom_range(0, 3) == 0) ? 32'h8000_0001
                                              : 32'($urandom_range(0, 1)),
                   32'($urandom_range(0, 5))};
            irq = (kind != 2) && any && ($urandom_range(0, 3) == 0);
            ef  = '0;
            if (kind == 2 || irq) begin
                for (int i = 0; i < N; i++)
                    if (m_en[i] && m_dl[i] == mn) begin
                        ef[i]   = 1;
                        m_en[i] = 0;
                    end
            end
            if (kind == 0) begin
                m_en[id] = 1;
                m_dl[id] = dl;
            end else if (kind == 1) begin
                m_en[id] = 0;
            end
            op(kind, id, dl, irq, f, t0);
            chk($sformatf("rnd%0d_fired", it), 64'(f), 64'(ef));
            any = model_min(mn);
            settle_check(any, mn, $sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_alarm_sched.md
TIMER_ALARM_SCHED -- requirements
Module: timer_alarm_sched

Interface
REQ-001 SHALL have parameter NumAlarms, default 4: number of software alarm slots, legal range 2..8.
REQ-002 SHALL have parameter AddressWidth, default 32: timer bus address width.
REQ-003 SHALL have parameter TimerBase, default 0: timer base address, 1kB aligned.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port arm_valid_i, input, 1: arm/cancel request.
REQ-007 SHALL have port arm_ready_o, output, 1: request accepted when both arm_valid_i and arm_ready_o are 1.
REQ-008 SHALL have port arm_id_i, input, $clog2(NumAlarms): target slot.
REQ-009 SHALL have port arm_enable_i, input, 1: 1 = arm the slot with the deadline, 0 = cancel the slot.
REQ-010 SHALL have port arm_deadline_i, input, 64: absolute mtime deadline.
REQ-011 SHALL have port fired_o, output, NumAlarms: one-cycle pulse bitmap of slots that fired.
REQ-012 SHALL have port err_o, output, 1: sticky timer bus error flag.
REQ-013 SHALL have ports timer_req_o, timer_we_o, timer_addr_o (AddressWidth), timer_be_o (4) and timer_wdata_o (32), all outputs: bus master to the timer.
REQ-014 SHALL have ports timer_rvalid_i, timer_err_i and timer_intr_i, all 1-bit inputs: timer response and timer interrupt.

Function
REQ-015 SHALL hold, per slot, a 64-bit deadline register and an enable bit.
REQ-016 SHALL use FSM states IDLE, SCAN, WR_HI_MAX, WR_LO, WR_HI and WAIT_IRQ.
REQ-017 SHALL drive arm_ready_o = 1 only in IDLE and WAIT_IRQ, decoded from registered state only.
REQ-018 SHALL, on an accepted arm, write the deadline and set the slot's enable bit; on an accepted cancel, clear the enable bit; either SHALL move the FSM to SCAN next cycle.
REQ-019 SHALL, in SCAN (one cycle), latch the target as the enabled slot with the minimum deadline (unsigned 64-bit compare, ties to the lowest index) together with its deadline.
REQ-020 SHALL go from SCAN to WR_HI_MAX when any slot is enabled, and otherwise to WR_HI_MAX followed by IDLE.
REQ-021 SHALL perform these writes: WR_HI_MAX writes 32'hFFFFFFFF to TimerBase+12; WR_LO writes deadline[31:0] to TimerBase+8; WR_HI writes deadline[63:32] to TimerBase+12.
REQ-022 SHALL, in each WR_* state, assert timer_req_o = 1, timer_we_o = 1 and timer_be_o = 4'hF only in the first cycle of that state.
REQ-023 SHALL, in each WR_* state, advance in the cycle timer_rvalid_i = 1 (WR_HI_MAX->WR_LO->WR_HI->WAIT_IRQ).
REQ-024 SHALL hold timer_req_o = 0 in all other cycles.
REQ-025 SHALL ignore arm_valid_i while in WR_* states; the requester holds its request.
REQ-026 SHALL set err_o when timer_rvalid_i and timer_err_i are both 1; the sequence continues regardless, and err_o clears only on reset.
REQ-027 SHALL, in WAIT_IRQ with timer_intr_i = 1, pulse fired_o for the target slot plus every enabled slot whose deadline equals the target deadline, clear their enable bits, and go to SCAN.
REQ-028 SHALL ignore timer_intr_i in all states other than WAIT_IRQ.
REQ-029 SHALL, when an arm or cancel and the interrupt occur in the same WAIT_IRQ cycle, apply the firing first and then the arm/cancel: an arm to a firing slot still fires and re-enables with the new deadline; a cancel to a firing slot still fires. Next state is SCAN.
REQ-030 SHALL, for an arm accepted in IDLE at cycle 0 with the timer responding 1 cycle after each request, issue requests at cycles 2, 4 and 6 and be in WAIT_IRQ at cycle 8.

Reset
REQ-031 SHALL, with rst_ni = 0 (asynchronous), set state to IDLE, clear all enable bits, and drive err_o = 0, fired_o = 0 and timer_req_o = 0.
REQ-032 SHALL, with rst_ni = 0, drive timer_we_o = 0, timer_addr_o = 0, timer_be_o = 0 and timer_wdata_o = 0.
REQ-033 SHALL leave deadline registers and the latched target without reset.
REQ-034 SHALL, on reset mid-write, abandon the write; no request is reissued after reset.

Verification
REQ-035 Arm slot 1 with 64'h0000_0001_0000_0100 from IDLE -> writes FFFFFFFF@+12, 00000100@+8, 00000001@+12 at cycles 2/4/6; WAIT_IRQ at cycle 8.
REQ-036 Slots 0 = 500 and 2 = 200 armed, then interrupt -> fired_o = 4'b0100 for one cycle; reprogram to 500; next interrupt -> fired_o = 4'b0001.
REQ-037 Slots 1 and 3 both = 300, then interrupt -> fired_o = 4'b1010; SCAN finds none enabled; WR_HI_MAX then IDLE.
REQ-038 In WAIT_IRQ targeting 1000, arm slot 0 = 50 -> SCAN, then writes 00000000@+12 and 00000032@+8 (after the FFFFFFFF write).
REQ-039 timer_err_i = 1 on the WR_LO response -> err_o = 1 and stays 1; sequence completes to WAIT_IRQ.
REQ-040 Reset during WR_LO -> all outputs 0 immediately; timer_intr_i = 1 afterwards -> no fired_o pulse.
